// File: rtl/frame_scheduler_pkg.sv
// rtl/frame_scheduler_pkg.sv - shared sizes, state encoding and slot constants for the frame scheduler
package frame_scheduler_pkg;

    localparam int NSLOT  = 16;
    localparam int WORD_W = 11;
    localparam int DIV_W  = 4;

    localparam logic [3:0] RTC_SLOT = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/frame_scheduler_slot_serializer.sv
// rtl/frame_scheduler_slot_serializer.sv - per-slot shift register with bit counter and bit-period divider
module slot_serializer #(
    parameter int WORD_W = frame_scheduler_pkg::WORD_W,
    parameter int DIV_W  = frame_scheduler_pkg::DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] par_data,
    input  logic [DIV_W-1:0]  div,
    output logic              msb,
    output logic              last_bit
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [DIV_W-1:0]  dcnt_q, dcnt_d;

    always_comb begin
        sr_d   = sr_q;
        bit_d  = bit_q;
        dcnt_d = dcnt_q;
        if (load) begin
            sr_d   = par_data;
            bit_d  = CNT_W'(WORD_W - 1);
            dcnt_d = div;
        end else if (shift_en) begin
            // A bit is held until the divider has counted down through zero.
            if (dcnt_q == '0) begin
                dcnt_d = div;
                sr_d   = {sr_q[WORD_W-2:0], 1'b0};
                if (bit_q != '0) begin
                    bit_d = bit_q - CNT_W'(1);
                end
            end else begin
                dcnt_d = dcnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            bit_q  <= '0;
            dcnt_q <= '0;
        end else begin
            sr_q   <= sr_d;
            bit_q  <= bit_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign msb      = sr_q[WORD_W-1];
    assign last_bit = shift_en && (bit_q == '0) && (dcnt_q == '0);

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-tick frame sequencer serializing each enabled slot word MSB first
module frame_scheduler #(
    parameter int NSLOT  = frame_scheduler_pkg::NSLOT,
    parameter int WORD_W = frame_scheduler_pkg::WORD_W,
    parameter int DIV_W  = frame_scheduler_pkg::DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [NSLOT-1:0]  ch_mask,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [WORD_W-1:0] par_data,
    input  logic              ovr_clr,
    output logic [3:0]        sel,
    output logic              load,
    output logic              sdo,
    output logic              sdo_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              acc_clr,
    output logic              busy,
    output logic              overrun
);
    import frame_scheduler_pkg::*;

    state_e             state_q, state_d;
    logic [3:0]         slot_q, slot_d;
    logic [NSLOT-1:0]   mask_q, mask_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               start_q, start_d;
    logic               ovr_q, ovr_d;

    logic               ser_shift;
    logic               ser_msb;
    logic               ser_last;

    logic               nxt_found;
    logic [3:0]         nxt_slot;
    logic [NSLOT-1:0]   enc_mask;
    int                 enc_floor;

    // Lowest enabled slot strictly above the current one; in IDLE the live mask is searched from slot 0.
    always_comb begin
        nxt_found = 1'b0;
        nxt_slot  = RTC_SLOT;
        enc_mask  = (state_q == ST_IDLE) ? ch_mask : mask_q;
        enc_floor = (state_q == ST_IDLE) ? 0 : int'(slot_q) + 1;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (enc_mask[i] && (i >= enc_floor)) begin
                nxt_found = 1'b1;
                nxt_slot  = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        mask_d     = mask_q;
        div_d      = div_q;
        start_d    = 1'b0;
        load       = 1'b0;
        sel        = 4'd0;
        sdo_valid  = 1'b0;
        frame_done = 1'b0;
        acc_clr    = 1'b0;
        ser_shift  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    mask_d  = ch_mask;
                    div_d   = cfg_div;
                    start_d = 1'b1;
                    if (nxt_found) begin
                        state_d = ST_LOAD;
                        slot_d  = nxt_slot;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                sel     = slot_q;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sel       = slot_q;
                sdo_valid = 1'b1;
                ser_shift = 1'b1;
                if (ser_last) begin
                    if (nxt_found) begin
                        state_d = ST_LOAD;
                        slot_d  = nxt_slot;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                acc_clr    = 1'b1;
                frame_done = 1'b1;
                slot_d     = RTC_SLOT;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set wins over clear; the CLEAR cycle already counts as busy.
    assign ovr_d = (ovr_q & ~ovr_clr) | (tick & (state_q != ST_IDLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= RTC_SLOT;
            mask_q  <= '0;
            div_q   <= '0;
            start_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            mask_q  <= mask_d;
            div_q   <= div_d;
            start_q <= start_d;
            ovr_q   <= ovr_d;
        end
    end

    slot_serializer #(
        .WORD_W (WORD_W),
        .DIV_W  (DIV_W)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift_en (ser_shift),
        .par_data (par_data),
        .div      (div_q),
        .msb      (ser_msb),
        .last_bit (ser_last)
    );

    assign sdo         = sdo_valid & ser_msb;
    assign busy        = (state_q != ST_IDLE);
    assign frame_start = start_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;

    localparam int NS = 16;
    localparam int W  = 11;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [NS-1:0] ch_mask = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [W-1:0]  par_data;
    logic [3:0]    sel;
    logic          load, sdo, sdo_valid, frame_start, frame_done, acc_clr, busy, overrun;

    logic [W-1:0]  wordtab [NS];
    logic [10:0]   act_o;

    int total = 0;
    int bad = 0;
    bit ovr_exp = 1'b0;

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  div;
        logic [10:0] word;
        int          exp_len;
        int          exp_loads;
    } vec_t;

    vec_t vt [6];

    frame_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .ch_mask     (ch_mask),
        .cfg_div     (cfg_div),
        .par_data    (par_data),
        .ovr_clr     (ovr_clr),
        .sel         (sel),
        .load        (load),
        .sdo         (sdo),
        .sdo_valid   (sdo_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .acc_clr     (acc_clr),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    assign par_data = wordtab[sel];
    assign act_o = {busy, frame_start, frame_done, acc_clr, load, sdo_valid, sdo, sel};

    function automatic logic [10:0] pk(input bit b, input bit fs, input bit fd, input bit ac,
                                       input bit ld, input bit sv, input bit sd, input logic [3:0] s);
        return {b, fs, fd, ac, ld, sv, sd, s};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs are built from the frame rules: per enabled slot one LOAD
    // cycle then every bit held div+1 cycles, and one closing CLEAR cycle.
    task automatic run_frame(input logic [15:0] m, input logic [3:0] d, input int tick_at,
                             input bit clr_too, input int mask_at, input logic [15:0] newm,
                             output int busy_n, output int load_n);
        logic [10:0] expq [$];
        logic [10:0] e, bad_a, bad_e;
        int first_bad;
        bit first;
        first = 1'b1;
        for (int s = 0; s < NS; s++) begin
            if (m[s]) begin
                expq.push_back(pk(1, first, 0, 0, 1, 0, 0, 4'(s)));
                first = 1'b0;
                for (int b = W - 1; b >= 0; b--) begin
                    for (int r = 0; r <= int'(d); r++) begin
                        expq.push_back(pk(1, 0, 0, 0, 0, 1, wordtab[s][b], 4'(s)));
                    end
                end
            end
        end
        expq.push_back(pk(1, first, 1, 1, 0, 0, 0, 4'd0));
        ch_mask = m;
        cfg_div = d;
        tick = 1'b1;
        step;
        tick = 1'b0;
        first_bad = -1;
        bad_a = '0;
        bad_e = '0;
        busy_n = 0;
        load_n = 0;
        for (int c = 0; c <= expq.size(); c++) begin
            e = (c < expq.size()) ? expq[c] : 11'd0;
            if (act_o[10]) busy_n++;
            if (act_o[6]) load_n++;
            if (act_o !== e && first_bad < 0) begin
                first_bad = c;
                bad_a = act_o;
                bad_e = e;
            end
            if (c == tick_at) begin
                tick = 1'b1;
                ovr_clr = clr_too;
                ovr_exp = 1'b1;
            end
            if (c == mask_at) begin
                ch_mask = newm;
                cfg_div = d + 4'd1;
            end
            step;
            tick = 1'b0;
            ovr_clr = 1'b0;
        end
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL trace mask=%h div=%0d cycle %0d: got %h want %h", m, d, first_bad, bad_a, bad_e);
        end
    endtask

    initial begin
        int bn, ln;
        logic [15:0] rm;
        vt[0] = '{16'hFFFF, 4'd0,  11'h5A5, 193, 16};
        vt[1] = '{16'h0005, 4'd2,  11'h5A5, 69,  2};
        vt[2] = '{16'h0000, 4'd7,  11'h000, 1,   0};
        vt[3] = '{16'h8000, 4'd0,  11'h7FF, 13,  1};
        vt[4] = '{16'h0001, 4'd15, 11'h401, 178, 1};
        vt[5] = '{16'h8001, 4'd1,  11'h123, 47,  2};
        for (int i = 0; i < NS; i++) wordtab[i] = 11'h5A5;

        // Reset wins over a simultaneous tick.
        rst_n = 1'b0;
        tick = 1'b1;
        ch_mask = 16'hFFFF;
        repeat (3) step;
        chk("reset_outputs", 32'(act_o), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        tick = 1'b0;
        rst_n = 1'b1;
        step;
        chk("post_reset_idle", 32'(act_o), 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NS; i++) wordtab[i] = vt[v].word;
            run_frame(vt[v].mask, vt[v].div, -1, 1'b0, -1, 16'h0, bn, ln);
            chk($sformatf("len_v%0d", v), 32'(bn), 32'(vt[v].exp_len));
            chk($sformatf("loads_v%0d", v), 32'(ln), 32'(vt[v].exp_loads));
        end
        chk("no_overrun", 32'(overrun), 32'(ovr_exp));

        for (int k = 0; k < 6; k++) begin
            rm = 16'($urandom);
            if ((k % 2) == 1) rm = rm & 16'($urandom);
            for (int i = 0; i < NS; i++) wordtab[i] = 11'($urandom);
            run_frame(rm, 4'($urandom_range(0, 3)), -1, 1'b0, -1, 16'h0, bn, ln);
        end

        run_frame(16'hFFFF, 4'd0, 50, 1'b0, -1, 16'h0, bn, ln);
        chk("ovr_len", 32'(bn), 32'd193);
        chk("ovr_set", 32'(overrun), 32'(ovr_exp));
        run_frame(16'h00FF, 4'd1, 10, 1'b1, -1, 16'h0, bn, ln);
        chk("ovr_set_and_clr", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        step;
        ovr_clr = 1'b0;
        ovr_exp = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        run_frame(16'h0000, 4'd0, 0, 1'b0, -1, 16'h0, bn, ln);
        chk("ovr_in_clear", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        step;
        ovr_clr = 1'b0;
        ovr_exp = 1'b0;

        run_frame(16'hFFFF, 4'd0, -1, 1'b0, 20, 16'h0001, bn, ln);
        chk("mask_chg_len", 32'(bn), 32'd193);
        run_frame(16'h0001, 4'd1, -1, 1'b0, -1, 16'h0, bn, ln);
        chk("mask_chg_next_len", 32'(bn), 32'd24);

        // Abort in slot 5 SHIFT: LOAD of slot 5 is cycle 60 after frame_start.
        ch_mask = 16'hFFFF;
        cfg_div = 4'd0;
        tick = 1'b1;
        step;
        tick = 1'b0;
        repeat (64) step;
        chk("mid_slot5", 32'({sel, sdo_valid, busy}), 32'({4'd5, 1'b1, 1'b1}));
        rst_n = 1'b0;
        step;
        chk("abort_outputs", 32'(act_o), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        step;
        chk("abort_hold", 32'(act_o), 32'd0);
        rst_n = 1'b1;
        step;
        chk("abort_idle", 32'(act_o), 32'd0);
        for (int i = 0; i < NS; i++) wordtab[i] = 11'($urandom);
        run_frame(16'h0021, 4'd0, -1, 1'b0, -1, 16'h0, bn, ln);
        chk("restart_len", 32'(bn), 32'd25);
        chk("restart_overrun", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter NSLOT, default 16: number of time slots per frame; slot 0 = RTC, slots 1..15 = CH1..CH15.
REQ-002 Parameter WORD_W, default 11: bits serialized per slot.
REQ-003 Parameter DIV_W, default 4: width of the bit-period divider.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 tick  in  1  frame trigger, one-cycle pulse from the timebase overflow.
REQ-007 ch_mask  in  NSLOT  slot enable mask; bit i enables slot i.
REQ-008 cfg_div  in  DIV_W  bit period minus one, in clk cycles.
REQ-009 par_data  in  WORD_W  parallel word of the source addressed by sel; valid in the same cycle.
REQ-010 ovr_clr  in  1  clears the overrun flag.
REQ-011 sel  out  4  source select for the channel mux.
REQ-012 load  out  1  one-cycle pulse; par_data is captured on this cycle.
REQ-013 sdo  out  1  serial data, MSB first.
REQ-014 sdo_valid  out  1  high while sdo carries a data bit.
REQ-015 frame_start  out  1  one-cycle pulse at frame begin.
REQ-016 frame_done  out  1  one-cycle pulse at frame end.
REQ-017 acc_clr  out  1  one-cycle accumulator clear, issued at frame end.
REQ-018 busy  out  1  high from frame_start through frame_done inclusive.
REQ-019 overrun  out  1  sticky: a tick arrived while busy.

Function
REQ-020 States: IDLE, LOAD, SHIFT, CLEAR.
REQ-021 IDLE: on tick=1, latch ch_mask and cfg_div into internal registers; the next state is LOAD at the lowest set mask bit, or CLEAR if the latched mask is 0.
REQ-022 frame_start pulses in the cycle after tick acceptance, coincident with the first LOAD or with CLEAR.
REQ-023 LOAD lasts exactly 1 cycle: load=1, sel=current slot, shift register <= par_data, bit counter <= WORD_W-1, divider <= latched cfg_div.
REQ-024 SHIFT: sdo=shift register MSB, sdo_valid=1, sel holds the slot value; each bit is held cfg_div+1 cycles, then the register shifts left with 0 fill.
REQ-025 After bit 0: go to LOAD for the next higher enabled slot if one exists, else go to CLEAR; there is no gap cycle between SHIFT and the following LOAD.
REQ-026 CLEAR lasts 1 cycle: acc_clr=1, frame_done=1, sel=0; the next state is IDLE.
REQ-027 Frame length = 1 + Σ over enabled slots (1 + WORD_W·(cfg_div+1)) cycles; all 16 slots at cfg_div=0 gives 193 cycles.
REQ-028 Mask and divider changes during a frame have no effect until the next accepted tick.
REQ-029 A tick while busy is ignored for sequencing and sets overrun; a tick in the CLEAR cycle also counts as overrun.
REQ-030 ovr_clr=1 clears overrun next cycle; simultaneous set and clear leaves overrun set.
REQ-031 Outside SHIFT, sdo=0 and sdo_valid=0; outside LOAD/SHIFT, sel=0.
REQ-032 Slot index arithmetic stays in 4 bits; slot NSLOT-1 is last, with no wrap to slot 0 within a frame.

Reset
REQ-033 rst_n=0 at a rising edge forces IDLE and clears the latched mask, latched divider, shift register, counters and overrun.
REQ-034 During and after reset, all outputs are 0 until the next tick.
REQ-035 Reset mid-frame aborts the frame immediately, with no frame_done or acc_clr pulse.
REQ-036 Reset has priority over tick and ovr_clr.

Structure
REQ-037 A shared package holds NSLOT, WORD_W, DIV_W, the state enumeration, and the RTC slot index constant (0).
REQ-038 One sub-module, slot_serializer, holds the shift register, bit counter and divider; it exposes load/start and last_bit.
REQ-039 Next-slot selection is a priority encoder over the latched mask bits above the current slot, inside frame_scheduler.

Verification
REQ-040 ch_mask=0xFFFF, cfg_div=0, tick -> 16 load pulses 12 cycles apart with sel 0..15, busy for 193 cycles, then acc_clr and frame_done in the same cycle.
REQ-041 ch_mask=0x0005, cfg_div=2, par_data=0x5A5 -> slots 0 and 2 only; each bit held 3 cycles; sdo sequence 10110100101 per slot; slot 2 LOAD immediately after slot 0 bit 0.
REQ-042 ch_mask=0x0000, tick -> frame_start, acc_clr and frame_done in one cycle; no load; busy high for 1 cycle.
REQ-043 Second tick 50 cycles into a frame -> frame unaffected, overrun=1; ovr_clr and a tick in the same cycle -> overrun stays 1; ovr_clr alone -> 0.
REQ-044 rst_n=0 during slot 5 SHIFT -> next cycle all outputs 0, no acc_clr; a following tick starts a clean frame at slot 0.
REQ-045 ch_mask changed from 0xFFFF to 0x0001 mid-frame -> current frame still covers all 16 slots; the next frame covers slot 0 only.
